// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised serial sequence detector. Watches a 1-bit stream and flags
// each occurrence of a run-time programmable pattern of 1..MAX_LEN bits.
// Supports overlapping / non-overlapping matching, an optional registered
// match output, input qualification and a saturating match counter.
//
// Parameters:
//   MAX_LEN    - maximum pattern length in bits (>= 2)
//   LEN_W      - width of pat_len; 2**LEN_W must exceed MAX_LEN
//   CNT_W      - width of match_count
//   OUTPUT_REG - 0: z is combinational (same cycle as completing bit)
//                1: z is registered (one cycle after completing bit)
//
// Ports:
//   clock       in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   load        in   latch pattern/pat_len/overlap and restart detection
//   pattern     in   pattern bits; pattern[pat_len-1] is received first
//   pat_len     in   pattern length, valid range 1..MAX_LEN
//   overlap     in   1 = overlapping matches, 0 = a match consumes its bits
//   en          in   qualifier for x
//   x           in   serial data bit
//   z           out  one-cycle match pulse
//   match_count out  matches since reset/load, saturating
//   count_sat   out  high while match_count is all ones
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int MAX_LEN    = 8,
    parameter int LEN_W      = 4,
    parameter int CNT_W      = 8,
    parameter int OUTPUT_REG = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               en,
    input  logic               x,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] FILL_ONE = LEN_W'(1);
    localparam logic [LEN_W:0]   EXT_ONE  = (LEN_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Latched configuration
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ov_q;

    // Detection state
    logic [MAX_LEN-2:0] hist_q;   // previously accepted bits, newest in LSB
    logic [LEN_W-1:0]   fill_q;   // number of valid history bits, saturating
    logic [CNT_W-1:0]   cnt_q;

    // Combinational match evaluation
    logic               accept;
    logic               len_ok;
    logic               fill_ok;
    logic               bits_ok;
    logic               match_cond;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_p1;

    always_comb begin
        accept  = en & ~load;
        // Candidate window: history followed by the bit being presented now.
        window  = {hist_q, x};

        // Only the low len_q bits of the window take part in the compare.
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len_q));
        end

        len_ok  = (len_q != '0) && (32'(len_q) <= MAX_LEN);
        // F >= L-1 rewritten as F+1 >= L to avoid underflow at L=0.
        fill_p1 = {1'b0, fill_q} + EXT_ONE;
        fill_ok = (fill_p1 >= {1'b0, len_q});
        bits_ok = (((window ^ pat_q) & mask) == '0);

        match_cond = accept & len_ok & fill_ok & bits_ok;
    end

    // Configuration registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= '0;
            len_q <= '0;
            ov_q  <= 1'b0;
        end else if (load) begin
            pat_q <= pattern;
            len_q <= pat_len;
            ov_q  <= overlap;
        end
    end

    // History and fill counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (load) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (en) begin
            hist_q <= window[MAX_LEN-2:0];
            // In non-overlap mode a match empties the fill count; the shifted
            // history bits stay but are masked until enough new bits arrive.
            if (match_cond && !ov_q) begin
                fill_q <= '0;
            end else if (fill_q < FILL_MAX) begin
                fill_q <= fill_q + FILL_ONE;
            end
        end
    end

    // Saturating match counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (match_cond && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign match_count = cnt_q;
    assign count_sat   = (cnt_q == '1);

    // Output timing selection
    generate
        if (OUTPUT_REG != 0) begin : g_z_reg
            logic z_q;
            // match_cond is already 0 during a load cycle, so the flop clears.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    z_q <= 1'b0;
                end else begin
                    z_q <= match_cond;
                end
            end
            assign z = z_q;
        end else begin : g_z_comb
            assign z = match_cond;
        end
    endgenerate

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       load;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       overlap;
    logic       en;
    logic       x;

    logic       za, zb, zc;
    logic [7:0] cnta, cntc;
    logic [1:0] cntb;
    logic       sata, satb, satc;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Default configuration: Mealy output, 8-bit counter
    seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .OUTPUT_REG(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .load(load), .pattern(pattern),
        .pat_len(pat_len), .overlap(overlap), .en(en), .x(x),
        .z(za), .match_count(cnta), .count_sat(sata));

    // Narrow counter for saturation
    seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2), .OUTPUT_REG(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .load(load), .pattern(pattern),
        .pat_len(pat_len), .overlap(overlap), .en(en), .x(x),
        .z(zb), .match_count(cntb), .count_sat(satb));

    // Registered output
    seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .OUTPUT_REG(1)) dut_c (
        .clock(clock), .reset_n(reset_n), .load(load), .pattern(pattern),
        .pat_len(pat_len), .overlap(overlap), .en(en), .x(x),
        .z(zc), .match_count(cntc), .count_sat(satc));

    typedef struct {
        logic       rst_n;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic       e;
        logic       xb;
        logic       ez;     // expected Mealy z of dut_a this cycle
        int         ecnt;   // expected dut_a match_count before the edge
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic [7:0] pat,
                         input logic [3:0] len, input logic ov, input logic e, input logic xb);
        @(negedge clock);
        reset_n = r; load = ld; pattern = pat; pat_len = len; overlap = ov; en = e; x = xb;
        #1;
    endtask

    task automatic add(input logic r, input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ov, input logic e, input logic xb, input logic ez, input int ecnt);
        vec_t v;
        v.rst_n = r; v.ld = ld; v.pat = pat; v.len = len; v.ov = ov;
        v.e = e; v.xb = xb; v.ez = ez; v.ecnt = ecnt;
        vt.push_back(v);
    endtask

    // Shorthands: accepted bit, load (with x=1,en=1 to show load wins), idle, reset
    task automatic addb(input logic xb, input logic ez, input int ecnt);
        add(1'b1, 1'b0, 8'h5A, 4'd3, 1'b0, 1'b1, xb, ez, ecnt);
    endtask
    task automatic addl(input logic [7:0] pat, input logic [3:0] len, input logic ov, input int ecnt);
        add(1'b1, 1'b1, pat, len, ov, 1'b1, 1'b1, 1'b0, ecnt);
    endtask
    task automatic addi(input int ecnt);
        add(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, ecnt);
    endtask

    initial begin
        reset_n = 1'b1; load = 1'b0; pattern = '0; pat_len = '0;
        overlap = 1'b0; en = 1'b0; x = 1'b0;

        // 1001 overlapping: matches on bits 4 and 7
        add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        addl(8'h09, 4'd4, 1'b1, 0);
        addb(1,0,0); addb(0,0,0); addb(0,0,0); addb(1,1,0);
        addb(0,0,1); addb(0,0,1); addb(1,1,1); addi(2);
        // 1001 non-overlapping: only bit 4
        addl(8'h09, 4'd4, 1'b0, 2);
        addb(1,0,0); addb(0,0,0); addb(0,0,0); addb(1,1,0);
        addb(0,0,1); addb(0,0,1); addb(1,0,1); addi(1);
        // Gaps with en=0 and x=1 change nothing
        addl(8'h09, 4'd4, 1'b1, 1);
        addb(1,0,0); addb(0,0,0); addi(0); addi(0); addi(0);
        addb(0,0,0); addb(1,1,0); addi(1);
        // pat_len=0 and pat_len=MAX_LEN+1 never match
        addl(8'h00, 4'd0, 1'b1, 1);
        addb(0,0,0); addb(0,0,0); addb(0,0,0); addb(1,0,0); addb(1,0,0);
        addl(8'hFF, 4'd9, 1'b1, 0);
        addb(1,0,0); addb(1,0,0); addb(1,0,0); addb(1,0,0); addb(1,0,0); addi(0);
        // Load during a partial match discards the earlier bits
        addl(8'h09, 4'd4, 1'b1, 0);
        addb(1,0,0); addb(0,0,0); addb(0,0,0);
        addl(8'h09, 4'd4, 1'b1, 0);
        addb(1,0,0); addb(0,0,0); addb(0,0,0); addb(1,1,0); addi(1);
        // Full-length pattern 10110010
        addl(8'hB2, 4'd8, 1'b0, 1);
        addb(1,0,0); addb(0,0,0); addb(1,0,0); addb(1,0,0);
        addb(0,0,0); addb(0,0,0); addb(1,0,0); addb(0,1,0); addi(1);
        // Single-bit pattern "0"
        addl(8'h00, 4'd1, 1'b0, 1);
        addb(0,1,0); addb(1,0,1); addb(0,1,1); addi(2);

        foreach (vt[i]) begin
            drive(vt[i].rst_n, vt[i].ld, vt[i].pat, vt[i].len, vt[i].ov, vt[i].e, vt[i].xb);
            check($sformatf("vec%0d_z", i), {31'd0, za}, {31'd0, vt[i].ez});
            check($sformatf("vec%0d_cnt", i), {24'd0, cnta}, vt[i].ecnt);
        end

        // Reset state
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        check("rst_sat_a", {31'd0, sata}, 0);
        check("rst_z_c", {31'd0, zc}, 0);
        check("rst_cnt_b", {30'd0, cntb}, 0);

        // Saturation with CNT_W=2, pattern "1"
        drive(1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
            check($sformatf("sat_z%0d", i), {31'd0, zb}, 1);
            check($sformatf("sat_cnt%0d", i), {30'd0, cntb}, (i < 3) ? i : 3);
            check($sformatf("sat_flag%0d", i), {31'd0, satb}, (i >= 3) ? 1 : 0);
        end
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        check("sat_cnt_end", {30'd0, cntb}, 3);
        check("sat_flag_end", {31'd0, satb}, 1);
        check("sat_cnt_a", {24'd0, cnta}, 5);

        // Registered output: z one cycle after the completing bit
        drive(1'b1, 1'b1, 8'h09, 4'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        check("reg_z_b1", {31'd0, zc}, 0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        check("reg_z_b2", {31'd0, zc}, 0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        check("reg_z_b3", {31'd0, zc}, 0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        check("reg_z_b4", {31'd0, zc}, 0);
        check("reg_mealy_b4", {31'd0, za}, 1);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        check("reg_z_after", {31'd0, zc}, 1);
        check("reg_cnt", {24'd0, cntc}, 1);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        check("reg_z_drop", {31'd0, zc}, 0);

        // Reset mid-stream 1,0,0 then a 1: nothing detected
        drive(1'b1, 1'b1, 8'h09, 4'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        check("midrst_cnt_c", {24'd0, cntc}, 0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        check("midrst_mealy", {31'd0, za}, 0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        check("midrst_z_c", {31'd0, zc}, 0);
        check("midrst_cnt_a", {24'd0, cnta}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector: watches a 1-bit input stream and flags each occurrence of a run-time programmable bit pattern of 1..MAX_LEN bits. Generalises the team's fixed 4-bit Mealy detectors with selectable overlap mode, an optional registered (Moore-timed) output, input qualification and a saturating match counter. Sits between a serial front end and the control/status logic that consumes match pulses and counts.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (>= 2).
- LEN_W, 4: width of pat_len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8: width of match_count.
- OUTPUT_REG, 0: 0 = Mealy z (combinational, same cycle as completing bit); 1 = z registered, one cycle later.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  latch pattern/pat_len/overlap; restart detection.
- pattern  in  MAX_LEN  pattern bits; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  in  LEN_W  pattern length; valid range 1..MAX_LEN.
- overlap  in  1  1 = overlapping matches allowed; 0 = a match consumes its bits.
- en  in  1  x qualifier; x is sampled only when en=1.
- x  in  1  serial data bit.
- z  out  1  one-cycle match pulse.
- match_count  out  CNT_W  number of matches since reset/load; saturates.
- count_sat  out  1  high while match_count is all ones.

## Operation
- Internal state: latched pattern P, length L, mode OV; history shift register H (MAX_LEN-1 bits, new bit enters LSB); fill counter F (0..MAX_LEN, saturating); match counter C.
- Reset (reset_n=0, asynchronous): P=0, L=0, OV=0, H=0, F=0, C=0, z=0, count_sat=0, registered-z flop=0.
- L=0 or L>MAX_LEN (latched as-is) is invalid: no match is ever flagged; H/F still update.
- Load cycle (load=1): on the edge, P/L/OV take the input values; H=0, F=0, C=0; x ignored regardless of en; z=0 that cycle. load has priority over en.
- Accepted bit (load=0, en=1): match_cond = (L valid) and (F >= L-1) and ({H[L-2:0], x} == P[L-1:0]); for L=1, compares x to P[0] only.
- On the edge: H shifts in x; F = min(F+1, MAX_LEN); if match_cond and OV=0, F=0 instead (H still shifts; stale bits are masked by F).
- If match_cond: C increments unless all ones (holds at all ones).
- en=0, load=0: H, F, C hold; match_cond=0.
- count_sat = (C == all ones), derived from the register.

## Timing
- OUTPUT_REG=0: z = match_cond, combinational from x/en/load and current state; high in the cycle the completing bit is presented; exactly one cycle per match.
- OUTPUT_REG=1: z is a flop loaded with match_cond; high the cycle after the completing bit; reset clears it; a load cycle forces the flop to 0.
- match_count updates on the same edge that accepts the completing bit (visible one cycle after Mealy z).
- Back-to-back matches (e.g. pattern "11", OV=1, stream 111) give z on consecutive cycles.
- Reset mid-pattern: partial match lost; pattern must be reloaded (P/L cleared).
- Simultaneous load and en/x: load wins; the bit is discarded.
- Pattern/pat_len/overlap inputs are ignored outside load cycles.

## Test plan
- Load pattern=…1001, pat_len=4, overlap=1; feed 1,0,0,1,0,0,1 with en=1 -> Mealy z high on bits 4 and 7; match_count=2.
- Same stream, overlap=0 -> z only on bit 4; match_count=1.
- overlap=1, pattern 1001, stream 1,0,(en=0 with x=1 for 3 cycles),0,1 -> z on final bit only; gaps change nothing.
- CNT_W=2, pattern "1" (pat_len=1), 5 accepted 1s -> z five times; match_count stops at 3; count_sat high from the 3rd match onward.
- OUTPUT_REG=1, pattern 1001, stream 1001 -> z high exactly one cycle after the 4th bit; assert reset_n=0 mid-stream 1,0,0 then feed 1 -> no z, match_count=0.
- pat_len=0 and pat_len=MAX_LEN+1 with arbitrary stream -> z never asserts, match_count stays 0; load during a pending partial match -> no match from pre-load bits.
